// File: rtl/pwm_multi.sv
// ---------------------------------------------------------------------------
// pwm_multi
//
// Multi-channel PWM generator. All channels share one period counter with a
// runtime-programmable terminal count and a runtime-selectable counting mode
// (edge-aligned or center-aligned). Each channel owns a shadow duty register,
// written at any time by load / inc / dec strobes, and an active duty
// register. The active register is refreshed from the shadow only at a
// period boundary, so a duty change can never produce a truncated pulse.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset (overrides en and strobes)
//   en           global enable; low holds the counter at 0, forces outputs low
//   period       terminal count P, taken at each period boundary
//   mode         0 = edge-aligned, 1 = center-aligned, taken at boundary
//   duty_load    per-channel strobe: shadow <= duty_in slice
//   duty_in      channel i duty in bits [i*WIDTH +: WIDTH]
//   duty_inc     per-channel saturating +1 of shadow
//   duty_dec     per-channel saturating -1 of shadow
//   pwm_out      registered PWM outputs
//   period_start registered one-cycle pulse on the first cycle of a period
//   duty_out     active (in-use) duty per channel, same packing as duty_in
// ---------------------------------------------------------------------------
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [WIDTH-1:0]          period,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       duty_load,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic [CHANNELS-1:0]       duty_inc,
    input  logic [CHANNELS-1:0]       duty_dec,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic [CHANNELS*WIDTH-1:0] duty_out
);

    localparam logic [WIDTH-1:0] DUTY_MAX = '1;
    localparam logic             DIR_UP   = 1'b0;
    localparam logic             DIR_DOWN = 1'b1;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == DUTY_MAX) ? v : v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? v : v - WIDTH'(1);
    endfunction

    logic [WIDTH-1:0] cnt;
    logic             dir;
    logic [WIDTH-1:0] period_act;
    logic             mode_act;
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic [WIDTH-1:0] active [CHANNELS];
    logic             boundary;

    // Shadow registers: written every cycle, independent of en.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                shadow[i] <= '0;
            end else if (duty_load[i]) begin
                shadow[i] <= duty_in[i*WIDTH +: WIDTH];
            end else if (duty_inc[i] && !duty_dec[i]) begin
                shadow[i] <= sat_inc(shadow[i]);
            end else if (duty_dec[i] && !duty_inc[i]) begin
                shadow[i] <= sat_dec(shadow[i]);
            end
        end
    end

    // Last cycle of the current period. In center mode the down-count ends
    // at 1 (not 0) so that the shared 0 is counted once per period; a zero
    // period makes every cycle a boundary.
    always_comb begin
        if (mode_act) begin
            boundary = ((dir == DIR_DOWN) && (cnt <= WIDTH'(1))) || (period_act == '0);
        end else begin
            boundary = (cnt >= period_act);
        end
    end

    // Counter / active-register stage and registered compare stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            period_act   <= '0;
            mode_act     <= 1'b0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                active[i] <= '0;
            end
        end else if (!en) begin
            // Idle: keep the configuration live so the first enabled cycle
            // starts a fresh period with the latest settings.
            cnt          <= '0;
            dir          <= DIR_UP;
            period_act   <= period;
            mode_act     <= mode;
            pwm_out      <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                active[i] <= shadow[i];
            end
        end else begin
            period_start <= (cnt == '0);
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= (active[i] > cnt);
            end

            if (boundary) begin
                cnt        <= '0;
                dir        <= DIR_UP;
                period_act <= period;
                mode_act   <= mode;
                for (int i = 0; i < CHANNELS; i++) begin
                    active[i] <= shadow[i];
                end
            end else if (!mode_act) begin
                cnt <= cnt + WIDTH'(1);
            end else if (dir == DIR_UP) begin
                if (cnt == period_act) begin
                    dir <= DIR_DOWN;
                    cnt <= cnt - WIDTH'(1);
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
            end else begin
                cnt <= cnt - WIDTH'(1);
            end
        end
    end

    always_comb begin
        duty_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            duty_out[i*WIDTH +: WIDTH] = active[i];
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi
//
// Directed testbench for pwm_multi (WIDTH=8, CHANNELS=4). Inputs change 1ns
// after the rising edge and outputs are sampled at the same point. Each
// scenario task carries its own hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_pwm_multi;

    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [W-1:0]    period;
    logic            mode;
    logic [CH-1:0]   duty_load;
    logic [CH*W-1:0] duty_in;
    logic [CH-1:0]   duty_inc;
    logic [CH-1:0]   duty_dec;
    logic [CH-1:0]   pwm_out;
    logic            period_start;
    logic [CH*W-1:0] duty_out;

    int          checks = 0;
    int          errors = 0;
    int          hi_cnt [CH];
    int          ps_cnt;
    logic [31:0] ps_pat;
    logic [31:0] ch0_pat;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .period       (period),
        .mode         (mode),
        .duty_load    (duty_load),
        .duty_in      (duty_in),
        .duty_inc     (duty_inc),
        .duty_dec     (duty_dec),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_out     (duty_out)
    );

    always #5 clk = ~clk;

    // Advance one clock; strobes are one-cycle pulses.
    task automatic step();
        @(posedge clk);
        #1;
        duty_load = '0;
        duty_inc  = '0;
        duty_dec  = '0;
    endtask

    task automatic set_duty(input int ch, input logic [W-1:0] val);
        duty_in[ch*W +: W] = val;
        duty_load[ch]      = 1'b1;
    endtask

    // Observe n consecutive samples starting with the current one; optionally
    // strobe a duty load during sample index load_at. Ends one sample later.
    task automatic window(input int n, input int load_at, input int ch, input logic [W-1:0] val);
        ps_cnt  = 0;
        ps_pat  = '0;
        ch0_pat = '0;
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
        for (int k = 0; k < n; k++) begin
            if (period_start) begin
                ps_cnt++;
                ps_pat[k] = 1'b1;
            end
            for (int c = 0; c < CH; c++) if (pwm_out[c]) hi_cnt[c]++;
            if (pwm_out[0]) ch0_pat[k] = 1'b1;
            if (k == load_at) set_duty(ch, val);
            step();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        en        = 1'b1;
        period    = 8'd9;
        mode      = 1'b0;
        duty_load = '1;
        duty_inc  = '1;
        duty_dec  = '1;
        duty_in   = {CH{8'hA5}};
        @(posedge clk);
        #1;
        checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL reset_pwm got %b want %b", pwm_out, 4'b0); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps got %b want %b", period_start, 1'b0); end
        checks++; if (duty_out !== 32'h0) begin errors++; $display("FAIL reset_duty got %h want %h", duty_out, 32'h0); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b0;
        duty_load = '0;
        duty_inc  = '0;
        duty_dec  = '0;
        step();
        checks++; if (duty_out !== 32'h0) begin errors++; $display("FAIL reset_release_duty got %h want %h", duty_out, 32'h0); end
    endtask

    task automatic test_edge_mode();
        en = 1'b0; period = 8'd9; mode = 1'b0;
        set_duty(0, 8'd3); set_duty(1, 8'd0); set_duty(2, 8'd12); set_duty(3, 8'd5);
        step(); step();
        checks++; if (duty_out !== 32'h050C0003) begin errors++; $display("FAIL edge_duty_out got %h want %h", duty_out, 32'h050C0003); end
        en = 1'b1;
        step();
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL edge_first_ps got %b want %b", period_start, 1'b1); end
        window(10, -1, 0, 8'd0);
        checks++; if (ps_pat !== 32'h1) begin errors++; $display("FAIL edge_ps_pattern got %h want %h", ps_pat, 32'h1); end
        checks++; if (ch0_pat !== 32'h7) begin errors++; $display("FAIL edge_ch0_pattern got %h want %h", ch0_pat, 32'h7); end
        checks++; if (hi_cnt[1] !== 0) begin errors++; $display("FAIL edge_ch1_high got %0d want %0d", hi_cnt[1], 0); end
        checks++; if (hi_cnt[2] !== 10) begin errors++; $display("FAIL edge_ch2_high got %0d want %0d", hi_cnt[2], 10); end
        checks++; if (hi_cnt[3] !== 5) begin errors++; $display("FAIL edge_ch3_high got %0d want %0d", hi_cnt[3], 5); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL edge_next_ps got %b want %b", period_start, 1'b1); end
    endtask

    task automatic test_mid_update();
        // load 7 while cnt=5: current period keeps 3
        window(10, 4, 0, 8'd7);
        checks++; if (hi_cnt[0] !== 3) begin errors++; $display("FAIL mid_cur_period got %0d want %0d", hi_cnt[0], 3); end
        window(10, -1, 0, 8'd0);
        checks++; if (hi_cnt[0] !== 7) begin errors++; $display("FAIL mid_next_period got %0d want %0d", hi_cnt[0], 7); end
        checks++; if (ps_cnt !== 1) begin errors++; $display("FAIL mid_ps_count got %0d want %0d", ps_cnt, 1); end
        // load 3 on the boundary cycle: visible two periods later
        window(10, 8, 0, 8'd3);
        checks++; if (hi_cnt[0] !== 7) begin errors++; $display("FAIL bnd_cur_period got %0d want %0d", hi_cnt[0], 7); end
        window(10, -1, 0, 8'd0);
        checks++; if (hi_cnt[0] !== 7) begin errors++; $display("FAIL bnd_next_period got %0d want %0d", hi_cnt[0], 7); end
        window(10, -1, 0, 8'd0);
        checks++; if (hi_cnt[0] !== 3) begin errors++; $display("FAIL bnd_later_period got %0d want %0d", hi_cnt[0], 3); end
    endtask

    task automatic test_saturation();
        en = 1'b0;
        step();
        set_duty(3, 8'd254); step();
        duty_inc[3] = 1'b1; step();
        duty_inc[3] = 1'b1; step();
        step();
        checks++; if (duty_out[31:24] !== 8'd255) begin errors++; $display("FAIL sat_inc got %0d want %0d", duty_out[31:24], 255); end
        checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL disabled_pwm got %b want %b", pwm_out, 4'b0); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL disabled_ps got %b want %b", period_start, 1'b0); end
        set_duty(3, 8'd1); step();
        duty_dec[3] = 1'b1; step();
        duty_dec[3] = 1'b1; step();
        step();
        checks++; if (duty_out[31:24] !== 8'd0) begin errors++; $display("FAIL sat_dec got %0d want %0d", duty_out[31:24], 0); end
        set_duty(3, 8'd100); step();
        duty_inc[3] = 1'b1; duty_dec[3] = 1'b1; step();
        step();
        checks++; if (duty_out[31:24] !== 8'd100) begin errors++; $display("FAIL inc_dec_hold got %0d want %0d", duty_out[31:24], 100); end
        set_duty(3, 8'd40); duty_inc[3] = 1'b1; step();
        step();
        checks++; if (duty_out[31:24] !== 8'd40) begin errors++; $display("FAIL load_over_inc got %0d want %0d", duty_out[31:24], 40); end
        duty_inc[3] = 1'b1; step();
        step();
        checks++; if (duty_out[31:24] !== 8'd41) begin errors++; $display("FAIL plain_inc got %0d want %0d", duty_out[31:24], 41); end
        checks++; if (duty_out[23:0] !== 24'h0C0003) begin errors++; $display("FAIL other_channels got %h want %h", duty_out[23:0], 24'h0C0003); end
    endtask

    task automatic test_center_mode();
        en = 1'b0; mode = 1'b1; period = 8'd4;
        set_duty(0, 8'd2); set_duty(1, 8'd5); set_duty(2, 8'd0); set_duty(3, 8'd4);
        step(); step();
        en = 1'b1;
        step();
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL ctr_first_ps got %b want %b", period_start, 1'b1); end
        window(8, -1, 0, 8'd0);
        checks++; if (ps_pat !== 32'h1) begin errors++; $display("FAIL ctr_ps_pattern got %h want %h", ps_pat, 32'h1); end
        checks++; if (ch0_pat !== 32'h83) begin errors++; $display("FAIL ctr_ch0_pattern got %h want %h", ch0_pat, 32'h83); end
        checks++; if (hi_cnt[1] !== 8) begin errors++; $display("FAIL ctr_ch1_high got %0d want %0d", hi_cnt[1], 8); end
        checks++; if (hi_cnt[2] !== 0) begin errors++; $display("FAIL ctr_ch2_high got %0d want %0d", hi_cnt[2], 0); end
        checks++; if (hi_cnt[3] !== 7) begin errors++; $display("FAIL ctr_ch3_high got %0d want %0d", hi_cnt[3], 7); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL ctr_next_ps got %b want %b", period_start, 1'b1); end
        // switch to edge mode inside a center period
        mode = 1'b0;
        window(8, -1, 0, 8'd0);
        checks++; if (ps_pat !== 32'h1) begin errors++; $display("FAIL switch_cur_ps got %h want %h", ps_pat, 32'h1); end
        checks++; if (ch0_pat !== 32'h83) begin errors++; $display("FAIL switch_cur_ch0 got %h want %h", ch0_pat, 32'h83); end
        window(5, -1, 0, 8'd0);
        checks++; if (ps_pat !== 32'h1) begin errors++; $display("FAIL switch_edge_ps got %h want %h", ps_pat, 32'h1); end
        checks++; if (hi_cnt[0] !== 2) begin errors++; $display("FAIL switch_edge_ch0 got %0d want %0d", hi_cnt[0], 2); end
        checks++; if (hi_cnt[1] !== 5) begin errors++; $display("FAIL switch_edge_ch1 got %0d want %0d", hi_cnt[1], 5); end
        checks++; if (hi_cnt[3] !== 4) begin errors++; $display("FAIL switch_edge_ch3 got %0d want %0d", hi_cnt[3], 4); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL switch_edge_next_ps got %b want %b", period_start, 1'b1); end
    endtask

    task automatic test_enable();
        en = 1'b0;
        step();
        period = 8'd9;
        set_duty(0, 8'd9); step();
        step();
        en = 1'b1;
        step();
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL en_first_ps got %b want %b", period_start, 1'b1); end
        checks++; if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL en_first_pwm got %b want %b", pwm_out[0], 1'b1); end
        for (int k = 1; k <= 5; k++) step();
        checks++; if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL en_cnt5_pwm got %b want %b", pwm_out[0], 1'b1); end
        en = 1'b0;
        step();
        checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL en_drop_pwm got %b want %b", pwm_out, 4'b0); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL en_drop_ps got %b want %b", period_start, 1'b0); end
        set_duty(0, 8'd2); step();
        step();
        checks++; if (duty_out[7:0] !== 8'd2) begin errors++; $display("FAIL en_idle_active got %0d want %0d", duty_out[7:0], 2); end
        en = 1'b1;
        step();
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL reen_ps got %b want %b", period_start, 1'b1); end
        checks++; if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL reen_pwm0 got %b want %b", pwm_out[0], 1'b1); end
        step();
        checks++; if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL reen_pwm1 got %b want %b", pwm_out[0], 1'b1); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reen_ps1 got %b want %b", period_start, 1'b0); end
        step();
        checks++; if (pwm_out[0] !== 1'b0) begin errors++; $display("FAIL reen_pwm2 got %b want %b", pwm_out[0], 1'b0); end
    endtask

    task automatic test_zero_period();
        en = 1'b0; period = 8'd0; mode = 1'b0;
        step();
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL p0_ps[%0d] got %b want %b", k, period_start, 1'b1); end
            checks++; if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL p0_pwm[%0d] got %b want %b", k, pwm_out[0], 1'b1); end
        end
    endtask

    task automatic test_reset_mid();
        period = 8'd9;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        step();
        checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL rstmid_pwm got %b want %b", pwm_out, 4'b0); end
        checks++; if (duty_out !== 32'h0) begin errors++; $display("FAIL rstmid_duty got %h want %h", duty_out, 32'h0); end
        rst = 1'b0;
        step();
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL rstmid_restart_ps got %b want %b", period_start, 1'b1); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; period = '0; mode = 1'b0;
        duty_load = '0; duty_in = '0; duty_inc = '0; duty_dec = '0;
        test_reset();
        test_edge_mode();
        test_mid_update();
        test_saturation();
        test_center_mode();
        test_enable();
        test_zero_period();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
